// File: rtl/seven_segment_reader.sv
// Seven-segment display reader: samples a multiplexed 4-digit display,
// debounces each digit dwell, decodes glyphs to hex nibbles and presents
// a complete frame with a valid/ack handshake.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic [3:0]  an,
  input  logic        frame_ack,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [10:0]     s_q, s_prev;
  logic [7:0]      cnt;
  logic            taken;
  logic [3:0]      mask, mask_d;
  logic [3:0][3:0] slots, slot_d;
  logic [3:0]      errs, err_d;

  logic [3:0] an_s;
  logic [6:0] seg_s;
  logic       changed, one_hot, accept, complete, exit_hold;
  logic [3:0] dec_nib;
  logic       dec_bad;

  assign an_s      = s_q[10:7];
  assign seg_s     = s_q[6:0];
  assign changed   = (s_q != s_prev);
  assign one_hot   = (an_s != 4'h0) && ((an_s & (an_s - 4'h1)) == 4'h0);
  // Counter still reflects the old dwell in a change cycle, so gate on !changed.
  assign accept    = !changed && (cnt == LAST) && !taken && one_hot && (state_q == COLLECT);
  assign complete  = accept && (mask_d == 4'hF);
  assign exit_hold = (state_q == HOLD) && frame_valid && frame_ack;

  // Glyph decode of {g,f,e,d,c,b,a}; unknown glyphs flag an error and give 0.
  always_comb begin
    dec_bad = 1'b0;
    case (seg_s)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_bad = 1'b1;
      end
    endcase
  end

  // Next slot/error/mask contents; the completing digit is bypassed into the frame copy.
  always_comb begin
    slot_d = slots;
    err_d  = errs;
    mask_d = mask;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (an_s[i]) begin
          slot_d[i] = dec_nib;
          err_d[i]  = dec_bad;
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (complete)  state_d = HOLD;
      HOLD:    if (exit_hold) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // Input sampling and dwell tracking (counter keeps running in HOLD).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      s_prev <= '0;
      cnt    <= '0;
      taken  <= 1'b0;
    end else begin
      s_q    <= {an, g, f, e, d, c, b, a};
      s_prev <= s_q;
      if (changed)          cnt <= '0;
      else if (cnt != LAST) cnt <= cnt + 8'd1;
      // A dwell stable at HOLD exit is marked consumed so it is not re-captured.
      if (changed)                        taken <= 1'b0;
      else if (exit_hold || cnt == LAST)  taken <= 1'b1;
    end
  end

  // Slot capture and frame presentation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots       <= '0;
      errs        <= '0;
      mask        <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      slots <= slot_d;
      errs  <= err_d;
      if (complete) begin
        digits      <= slot_d;
        digit_err   <= err_d;
        mask        <= '0;
        frame_valid <= 1'b1;
      end else begin
        mask <= mask_d;
        if (exit_hold) frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader (STABLE_CYCLES = 4).
module tb_seven_segment_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0;
  logic [3:0]  an = 4'h0;
  logic        frame_ack = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int checks = 0;
  int failures = 0;

  seven_segment_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an(an), .frame_ack(frame_ack),
    .digits(digits), .digit_err(digit_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] sel, input logic [6:0] pat);
    an = sel;
    {g, f, e, d, c, b, a} = pat;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dwell(input logic [3:0] sel, input logic [6:0] pat, input int n);
    drive(sel, pat);
    step(n);
  endtask

  task automatic test_reset;
    drive(4'h0, 7'h00);
    step(2);
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (digit_err !== 4'h0) begin failures++; $display("FAIL reset_err got=%b exp=0000", digit_err); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic_scan;
    dwell(4'b0001, 7'h06, 8);
    dwell(4'b0010, 7'h5B, 8);
    dwell(4'b0100, 7'h4F, 8);
    drive(4'b1000, 7'h66);
    step(5);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", frame_valid); end
    frame_ack = 1'b1;  // ack in the completing cycle must be ignored
    step(1);
    frame_ack = 1'b0;
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h4321) begin failures++; $display("FAIL basic_digits got=%h exp=4321", digits); end
    checks++; if (digit_err !== 4'h0) begin failures++; $display("FAIL basic_err got=%b exp=0000", digit_err); end
    step(2);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_valid got=%b exp=0", frame_valid); end
    checks++; if (digits !== 16'h4321) begin failures++; $display("FAIL basic_ack_retain got=%h exp=4321", digits); end
  endtask

  task automatic test_short_dwell;
    dwell(4'b0001, 7'h3F, 8);
    dwell(4'b0010, 7'h06, 8);
    dwell(4'b0100, 7'h7F, 3);
    dwell(4'b0000, 7'h7F, 8);
    dwell(4'b1000, 7'h66, 8);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL short_no_frame got=%b exp=0", frame_valid); end
    drive(4'b0100, 7'h7F);
    step(5);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL short_early got=%b exp=0", frame_valid); end
    step(1);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL short_valid got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h4810) begin failures++; $display("FAIL short_digits got=%h exp=4810", digits); end
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL short_ack got=%b exp=0", frame_valid); end
  endtask

  task automatic test_bad_glyph;
    frame_ack = 1'b1;  // ack while no frame is presented has no effect
    dwell(4'b0001, 7'h3F, 8);
    dwell(4'b0010, 7'h7E, 8);
    dwell(4'b0100, 7'h5B, 8);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL bad_partial got=%b exp=0", frame_valid); end
    frame_ack = 1'b0;
    dwell(4'b1000, 7'h4F, 8);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL bad_valid got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h3200) begin failures++; $display("FAIL bad_digits got=%h exp=3200", digits); end
    checks++; if (digit_err !== 4'b0010) begin failures++; $display("FAIL bad_err got=%b exp=0010", digit_err); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 4; i++) dwell(4'(1 << i), 7'h3F, 25);
    checks++; if (digits !== 16'h3200) begin failures++; $display("FAIL hold_digits got=%h exp=3200", digits); end
    checks++; if (digit_err !== 4'b0010) begin failures++; $display("FAIL hold_err got=%b exp=0010", digit_err); end
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", frame_valid); end
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL hold_ack got=%b exp=0", frame_valid); end
    checks++; if (digits !== 16'h3200) begin failures++; $display("FAIL hold_retain got=%h exp=3200", digits); end
    for (int i = 0; i < 4; i++) dwell(4'(1 << i), 7'h3F, 8);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL rescan_valid got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL rescan_digits got=%h exp=0000", digits); end
    checks++; if (digit_err !== 4'h0) begin failures++; $display("FAIL rescan_err got=%b exp=0000", digit_err); end
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
  endtask

  task automatic test_two_hot_and_reset;
    dwell(4'b0001, 7'h06, 8);
    dwell(4'b0010, 7'h06, 8);
    dwell(4'b0100, 7'h06, 8);
    dwell(4'b0011, 7'h5B, 20);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL twohot_valid got=%b exp=0", frame_valid); end
    dwell(4'b1000, 7'h66, 8);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL twohot_frame got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h4111) begin failures++; $display("FAIL twohot_digits got=%h exp=4111", digits); end
    #2 reset = 1'b1;
    #1;
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL async_rst_digits got=%h exp=0000", digits); end
    checks++; if (digit_err !== 4'h0) begin failures++; $display("FAIL async_rst_err got=%b exp=0000", digit_err); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", frame_valid); end
    drive(4'b0001, 7'h06);
    step(2);
    reset = 1'b0;
    step(10);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", frame_valid); end
    checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL post_rst_digits got=%h exp=0000", digits); end
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_short_dwell;
    test_bad_glyph;
    test_hold;
    test_two_hot_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
